// File: rtl/shift_sequencer_pkg.sv
// Shared types and defaults for the shift sequencer and its step ticker.
package shift_sequencer_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_RATE  = 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        CAPTURE
    } state_t;

endpackage

// File: rtl/shift_sequencer_step_ticker.sv
// Down-counter pacing shift steps: reloads to RATE-1, ticks for one cycle at zero.
module step_ticker
    import shift_sequencer_pkg::*;
#(
    parameter int unsigned RATE = DEF_RATE
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_reload,
    input  logic i_en,
    output logic o_tick
);

    localparam int unsigned   CW     = $clog2(RATE + 1);
    localparam logic [CW-1:0] RELOAD = CW'(RATE - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_reload) begin
            r_cnt <= RELOAD;
        end else if (i_en) begin
            r_cnt <= (r_cnt == '0) ? RELOAD : r_cnt - CW'(1);
        end
    end

    assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/shift_sequencer.sv
// Sequences load, N paced right shifts and capture of an external 8-bit shifter
// from a single start request, reporting the captured value with a done pulse.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned RATE  = DEF_RATE
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [WIDTH-1:0]         data_in,
    input  logic [$clog2(WIDTH)-1:0] amount,
    input  logic                     arith,
    input  logic [WIDTH-1:0]         q_in,
    output logic                     load_n,
    output logic                     shift_right,
    output logic                     asr,
    output logic [WIDTH-1:0]         load_val,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         result
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_data;
    logic [CW-1:0]    r_count;
    logic             r_arith;
    logic [WIDTH-1:0] r_result;
    logic             r_done;
    logic             w_tick;

    step_ticker #(
        .RATE (RATE)
    ) u_ticker (
        .i_clk    (clk),
        .i_rst_n  (reset_n),
        .i_reload (r_state == LOAD),
        .i_en     (r_state == SHIFT),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = LOAD;
            LOAD:    w_next = (r_count == '0) ? CAPTURE : SHIFT;
            SHIFT:   if (w_tick && (r_count == CW'(1))) w_next = CAPTURE;
            CAPTURE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (abort && (r_state != IDLE)) begin
            w_next = IDLE;
        end
    end

    // Operand latches, shift count and result capture; abort suppresses the capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data   <= '0;
            r_count  <= '0;
            r_arith  <= 1'b0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_data  <= data_in;
                        r_count <= amount;
                        r_arith <= arith;
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        r_count <= r_count - CW'(1);
                    end
                end
                CAPTURE: begin
                    if (!abort) begin
                        r_result <= q_in;
                        r_done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        load_n      = 1'b1;
        shift_right = 1'b0;
        asr         = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: ;
            LOAD: begin
                load_n = 1'b0;
                asr    = r_arith;
                busy   = 1'b1;
            end
            SHIFT: begin
                shift_right = w_tick;
                asr         = r_arith;
                busy        = 1'b1;
            end
            CAPTURE: begin
                asr  = r_arith;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    assign load_val = r_data;
    assign done     = r_done;
    assign result   = r_result;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer at RATE=1 and RATE=3, each driving a behavioural shifter.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       sel3 = 1'b0;
    logic [7:0] data_in = '0;
    logic [2:0] amount = '0;
    logic       arith = 1'b0;

    logic       load_n1, shift1, asr1, busy1, done1;
    logic [7:0] load_val1, result1, q1;
    logic       load_n3, shift3, asr3, busy3, done3;
    logic [7:0] load_val3, result3, q3;

    logic       m_load_n, m_shift, m_asr, m_busy, m_done;
    logic [7:0] m_load_val, m_result;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.WIDTH(8), .RATE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start && !sel3), .abort(abort),
        .data_in(data_in), .amount(amount), .arith(arith), .q_in(q1),
        .load_n(load_n1), .shift_right(shift1), .asr(asr1), .load_val(load_val1),
        .busy(busy1), .done(done1), .result(result1)
    );

    shift_sequencer #(.WIDTH(8), .RATE(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start && sel3), .abort(abort),
        .data_in(data_in), .amount(amount), .arith(arith), .q_in(q3),
        .load_n(load_n3), .shift_right(shift3), .asr(asr3), .load_val(load_val3),
        .busy(busy3), .done(done3), .result(result3)
    );

    // Behavioural load/shift-right registers on the same clock as the sequencers.
    always @(posedge clk) begin
        if (!load_n1)    q1 <= load_val1;
        else if (shift1) q1 <= {asr1 & q1[7], q1[7:1]};
        if (!load_n3)    q3 <= load_val3;
        else if (shift3) q3 <= {asr3 & q3[7], q3[7:1]};
    end

    assign m_load_n   = sel3 ? load_n3   : load_n1;
    assign m_shift    = sel3 ? shift3    : shift1;
    assign m_asr      = sel3 ? asr3      : asr1;
    assign m_busy     = sel3 ? busy3     : busy1;
    assign m_done     = sel3 ? done3     : done1;
    assign m_load_val = sel3 ? load_val3 : load_val1;
    assign m_result   = sel3 ? result3   : result1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic s3, input logic [7:0] d, input logic [2:0] n, input logic a,
                         input logic [7:0] exp_res, input int exp_done, input int exp_first,
                         input int exp_gap, input string tag);
        int   shifts[$];
        int   load_cyc  = -1;
        int   done_cyc  = -1;
        logic asr_seen  = 1'b0;
        sel3 = s3; data_in = d; amount = n; arith = a; start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (!m_load_n && load_cyc < 0) load_cyc = c;
            if (m_shift) shifts.push_back(c);
            if (m_asr) asr_seen = 1'b1;
            if (m_done) begin
                done_cyc = c;
                break;
            end
            next_cycle();
        end
        chk({tag, ":load_cycle"}, load_cyc, 1);
        chk({tag, ":done_cycle"}, done_cyc, exp_done);
        chk({tag, ":result"}, {24'h0, m_result}, {24'h0, exp_res});
        chk({tag, ":n_shifts"}, shifts.size(), {29'h0, n});
        if (shifts.size() > 0) chk({tag, ":first_shift"}, shifts[0], exp_first);
        for (int i = 1; i < shifts.size(); i++)
            chk({tag, ":shift_gap"}, shifts[i] - shifts[i-1], exp_gap);
        chk({tag, ":asr_seen"}, {31'h0, asr_seen}, {31'h0, a});
        chk({tag, ":busy_at_done"}, {31'h0, m_busy}, 32'h0);
    endtask

    initial begin
        int seen_done;
        #2;
        chk("rst:load_n", {31'h0, load_n1}, 32'h1);
        chk("rst:shift", {31'h0, shift1}, 32'h0);
        chk("rst:busy", {31'h0, busy1}, 32'h0);
        chk("rst:done", {31'h0, done1}, 32'h0);
        chk("rst:result", {24'h0, result1}, 32'h0);
        chk("rst:load_val", {24'h0, load_val1}, 32'h0);
        #10 reset_n = 1'b1;
        next_cycle();

        do_op(1'b0, 8'h96, 3'd3, 1'b1, 8'hF2, 6, 2, 1, "asr3");
        do_op(1'b0, 8'h96, 3'd3, 1'b0, 8'h12, 6, 2, 1, "lsr3");
        do_op(1'b0, 8'h5A, 3'd0, 1'b0, 8'h5A, 3, 0, 1, "zero");
        do_op(1'b1, 8'h80, 3'd2, 1'b1, 8'hE0, 9, 4, 3, "rate3");

        // start while busy is dropped; start in the done cycle is accepted
        sel3 = 1'b0; data_in = 8'h96; amount = 3'd3; arith = 1'b0; start = 1'b1;
        next_cycle();                                   // cycle 1
        start = 1'b0;
        next_cycle();                                   // cycle 2
        data_in = 8'hFF; amount = 3'd1; start = 1'b1;
        next_cycle();                                   // cycle 3
        start = 1'b0;
        chk("busy_start:load_n", {31'h0, load_n1}, 32'h1);
        chk("busy_start:busy", {31'h0, busy1}, 32'h1);
        next_cycle();
        next_cycle();
        next_cycle();                                   // cycle 6
        chk("busy_start:done", {31'h0, done1}, 32'h1);
        chk("busy_start:result", {24'h0, result1}, 32'h12);
        data_in = 8'h5A; amount = 3'd0; arith = 1'b1; start = 1'b1;
        next_cycle();
        start = 1'b0;
        chk("done_start:load_n", {31'h0, load_n1}, 32'h0);
        chk("done_start:load_val", {24'h0, load_val1}, 32'h5A);
        chk("done_start:asr", {31'h0, asr1}, 32'h1);
        next_cycle();
        next_cycle();
        chk("done_start:done", {31'h0, done1}, 32'h1);
        chk("done_start:result", {24'h0, result1}, 32'h5A);

        // abort in SHIFT
        data_in = 8'hF0; amount = 3'd3; arith = 1'b0; start = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        chk("abort:busy", {31'h0, busy1}, 32'h0);
        seen_done = 0;
        for (int c = 0; c < 8; c++) begin
            if (done1) seen_done++;
            next_cycle();
        end
        chk("abort:no_done", seen_done, 0);
        chk("abort:result", {24'h0, result1}, 32'h5A);

        // asynchronous reset in SHIFT
        data_in = 8'hF0; amount = 3'd3; arith = 1'b1; start = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        chk("prereset:shift", {31'h0, shift1}, 32'h1);
        #3 reset_n = 1'b0;
        #1;
        chk("midrst:load_n", {31'h0, load_n1}, 32'h1);
        chk("midrst:shift", {31'h0, shift1}, 32'h0);
        chk("midrst:asr", {31'h0, asr1}, 32'h0);
        chk("midrst:busy", {31'h0, busy1}, 32'h0);
        chk("midrst:load_val", {24'h0, load_val1}, 32'h0);
        chk("midrst:result", {24'h0, result1}, 32'h0);
        #2 reset_n = 1'b1;
        next_cycle();
        chk("postrst:busy", {31'h0, busy1}, 32'h0);

        do_op(1'b0, 8'h96, 3'd3, 1'b1, 8'hF2, 6, 2, 1, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Control stage that sits directly upstream of the 8-bit load/shift-right register and drives its load, shift and arithmetic-select controls. On a single `start` request it loads an operand into the shifter, issues a programmed number of one-bit right shifts at a configurable step rate, then captures the shifter's output and reports it with a one-cycle `done` pulse. It turns manual key-press sequencing into a single-command operation.

## Interface
Parameters:
- `WIDTH`, 8: operand and shifter width.
- `RATE`, 1: clock cycles per shift step, legal range 1 and up; 0 is illegal.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; returns to IDLE with no `done`.
- `data_in`  in  WIDTH  operand, latched on accepted `start`.
- `amount`  in  $clog2(WIDTH)  shift count, 0..WIDTH-1, latched on accepted `start`.
- `arith`  in  1  1 = arithmetic shift (sign fill), 0 = logical; latched on accepted `start`.
- `q_in`  in  WIDTH  shifter register output.
- `load_n`  out  1  shifter load, active-low.
- `shift_right`  out  1  shifter shift enable, active-high.
- `asr`  out  1  shifter sign-extension select.
- `load_val`  out  WIDTH  shifter parallel load value.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; `result` is valid from this cycle.
- `result`  out  WIDTH  captured shifter value, held until the next capture.

## Operation
- States: IDLE, LOAD, SHIFT, CAPTURE. Shifter control outputs are Moore-decoded from the state register only.
- IDLE: `start`=1 latches `data_in`, `amount` and `arith`, then moves to LOAD. All other inputs are ignored.
- LOAD (1 cycle): `load_n`=0 and `load_val`=latched data. Moves to CAPTURE if the count is 0, otherwise to SHIFT with count = `amount` and tick = RATE-1.
- SHIFT: tick decrements each cycle. `shift_right`=1 in cycles where tick==0; tick then reloads RATE-1 and count decrements. After the pulse that takes count to 0, moves to CAPTURE.
- `asr` equals latched `arith` in LOAD, SHIFT and CAPTURE, and is 0 in IDLE.
- CAPTURE (1 cycle): `result` <= `q_in` at the closing edge. The closing edge also sets `done`=1 for one cycle and moves to IDLE.
- `load_val` holds the latched operand while busy and holds its last value in IDLE.
- `abort`=1 in any busy state moves to IDLE at the next edge. It produces no `done`, leaves `result` unchanged, and overrides `start`.
- Simultaneous events: `start` in the `done` cycle is accepted, because the state is already IDLE. `start` while busy is dropped and not queued.

## Timing
- Reset values: `load_n`=1, `shift_right`=0, `asr`=0, `load_val`=0, `busy`=0, `done`=0, `result`=0; state IDLE, counters 0.
- `reset_n` low at any point, including mid-operation, forces all outputs to their reset values immediately. Operation restarts only on a new `start` after release.
- Latency: with `start` accepted at edge E0, LOAD occupies cycle 1. SHIFT occupies cycles 2..1+N·RATE. CAPTURE occupies cycle 2+N·RATE. `done` is high in cycle 3+N·RATE.
- For N=0, SHIFT is skipped and `done` is high in cycle 3.
- `shift_right` pulses exactly N times, each one cycle wide, spaced RATE cycles apart. For RATE=1 the pulses are contiguous.
- The shifter registers on the same `clk`, so `q_in` in CAPTURE reflects all N shifts.

## Structure
- The shared package holds the state enum (IDLE, LOAD, SHIFT, CAPTURE) and the default WIDTH/RATE constants.
- One sub-module, `step_ticker`: a down-counter of width $clog2(RATE+1) with reload and enable, producing a one-cycle `tick`.
- The top level holds the FSM, operand latches, count register and `result` register.

## Test plan
- Reset, then `data_in`=0x96, `amount`=3, `arith`=1, RATE=1, against a behavioural shifter model. Expected: `load_n` low in cycle 1, `shift_right` high in cycles 2–4, `done` in cycle 6, `result`=0xF2.
- Same stimulus with `arith`=0. Expected: `result`=0x12 and `asr` low throughout.
- `amount`=0, `data_in`=0x5A. Expected: no `shift_right` pulses, `done` in cycle 3, `result`=0x5A.
- RATE=3, `amount`=2, `data_in`=0x80, `arith`=1. Expected: `shift_right` pulses exactly 3 cycles apart, `done` in cycle 9, `result`=0xE0.
- Assert `start` while busy and again in the `done` cycle. Expected: the first is ignored; the second starts a new LOAD in the next cycle.
- Assert `abort` in SHIFT, and separately pulse `reset_n` low in SHIFT. Expected: abort returns to IDLE with no `done` and unchanged `result`; reset clears all outputs asynchronously and sets `result`=0.
